// File: rtl/eval_report_pkg.sv
// Shared constants, FSM state type and checksum helper for the
// evaluation-report transmitter.
package eval_report_pkg;

   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   localparam logic [7:0] ID_BR  = 8'h01;
   localparam logic [7:0] ID_IPC = 8'h02;
   localparam logic [7:0] ID_MEM = 8'h03;

   // Bytes per frame: header, id, value high, value low, checksum.
   localparam int unsigned FRAME_LEN = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ID,
      ST_VHI,
      ST_VLO,
      ST_CSUM
   } state_e;

   // Checksum covers the id and both value bytes; the header is excluded.
   function automatic logic [7:0] frame_csum(input logic [7:0] id,
                                             input logic [15:0] val);
      return id ^ val[15:8] ^ val[7:0];
   endfunction

endpackage

// File: rtl/eval_report_slot.sv
// One result slot: holds the latest published value (zero-extended to
// 16 bits) and a pending flag, and flags an overwrite of an unsent value.
module eval_report_slot #(
   parameter int unsigned W = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_upd,
   input  logic [W-1:0] i_val,
   input  logic         i_capture,
   output logic [15:0]  o_val,
   output logic         o_pending,
   output logic         o_overwrite
);

   logic [15:0] val_q, val_d;
   logic        pend_q, pend_d;

   // Next value and pending flag; a same-cycle update wins over the capture clear.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      val_d  = val_q;
      pend_d = pend_q;
      if (i_capture) begin
         pend_d = 1'b0;
      end
      if (i_upd) begin
         val_d  = 16'(i_val);
         pend_d = 1'b1;
      end
   end

   // Slot storage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         val_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         val_q  <= val_d;
         pend_q <= pend_d;
      end
   end

   // A capture in the same cycle consumes the old value, so that is not a loss.
   assign o_overwrite = i_upd & pend_q & ~i_capture;
   assign o_val       = val_q;
   assign o_pending   = pend_q;

endmodule

// File: rtl/eval_report_tx.sv
// Samples branch/IPC/memory evaluation results into slots and streams each
// one as a 5-byte frame (HDR, id, val hi, val lo, csum) over valid/ready.
module eval_report_tx
   import eval_report_pkg::*;
#(
   parameter int unsigned BR_W     = 10,
   parameter int unsigned IPC_W    = 10,
   parameter int unsigned MEM_W    = 7,
   parameter logic [7:0]  HDR_BYTE = HDR_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [BR_W-1:0]  i_br_eval,
   input  logic             i_br_upd,
   input  logic [IPC_W-1:0] i_ipc_eval,
   input  logic             i_ipc_upd,
   input  logic [MEM_W-1:0] i_mem_eval,
   input  logic             i_mem_upd,
   output logic             o_tx_valid,
   output logic [7:0]       o_tx_data,
   input  logic             i_tx_ready,
   output logic [7:0]       o_drop_cnt,
   output logic             o_busy
);

   if (BR_W < 1 || BR_W > 16 || IPC_W < 1 || IPC_W > 16 || MEM_W < 1 || MEM_W > 16) begin : g_bad_width
      $error("eval_report_tx: result widths must be 1..16");
   end

   logic [2:0]  pend, cap, ovw;
   logic [15:0] val_br, val_ipc, val_mem;

   eval_report_slot #(.W(BR_W)) u_slot_br (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_upd(i_br_upd), .i_val(i_br_eval),
      .i_capture(cap[0]), .o_val(val_br), .o_pending(pend[0]), .o_overwrite(ovw[0])
   );
   eval_report_slot #(.W(IPC_W)) u_slot_ipc (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_upd(i_ipc_upd), .i_val(i_ipc_eval),
      .i_capture(cap[1]), .o_val(val_ipc), .o_pending(pend[1]), .o_overwrite(ovw[1])
   );
   eval_report_slot #(.W(MEM_W)) u_slot_mem (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_upd(i_mem_upd), .i_val(i_mem_eval),
      .i_capture(cap[2]), .o_val(val_mem), .o_pending(pend[2]), .o_overwrite(ovw[2])
   );

   state_e      state_q, state_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  id_q, id_d;
   logic [15:0] val_q, val_d;
   logic [7:0]  csum_q, csum_d;
   logic [1:0]  rr_q, rr_d;
   logic [7:0]  drop_q, drop_d;

   logic [1:0]  sel_idx;
   logic [7:0]  sel_id;
   logic [15:0] sel_val;
   logic        accept;
   logic [9:0]  drop_sum;

   // Round-robin pick: first pending slot at or after rr_q.
   always_comb begin
      sel_idx = 2'd0;
      case (rr_q)
         2'd1:    sel_idx = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
         2'd2:    sel_idx = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
         default: sel_idx = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
      endcase
      case (sel_idx)
         2'd0:    begin sel_id = ID_BR;  sel_val = val_br;  end
         2'd1:    begin sel_id = ID_IPC; sel_val = val_ipc; end
         default: begin sel_id = ID_MEM; sel_val = val_mem; end
      endcase
      cap = (state_q == ST_IDLE && |pend) ? (3'b001 << sel_idx) : 3'b000;
   end

   // Frame sequencing: capture in IDLE, then step one byte per accepted handshake.
   always_comb begin
      state_d    = state_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      id_d       = id_q;
      val_d      = val_q;
      csum_d     = csum_q;
      rr_d       = rr_q;
      accept     = tx_valid_q & i_tx_ready;
      case (state_q)
         ST_IDLE: begin
            if (|pend) begin
               id_d       = sel_id;
               val_d      = sel_val;
               csum_d     = frame_csum(sel_id, sel_val);
               rr_d       = (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
               state_d    = ST_HDR;
               tx_valid_d = 1'b1;
               tx_data_d  = HDR_BYTE;
            end
         end
         ST_HDR:  if (accept) begin state_d = ST_ID;   tx_data_d = id_q;        end
         ST_ID:   if (accept) begin state_d = ST_VHI;  tx_data_d = val_q[15:8]; end
         ST_VHI:  if (accept) begin state_d = ST_VLO;  tx_data_d = val_q[7:0];  end
         ST_VLO:  if (accept) begin state_d = ST_CSUM; tx_data_d = csum_q;      end
         ST_CSUM: begin
            if (accept) begin
               state_d    = ST_IDLE;
               tx_valid_d = 1'b0;
               tx_data_d  = 8'h00;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
   end

   // Saturating count of results lost to overwrite; several may land in one cycle.
   always_comb begin
      drop_sum = 10'(drop_q) + 10'(ovw[0]) + 10'(ovw[1]) + 10'(ovw[2]);
      drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
   end

   // FSM, registered outputs, captured frame and drop counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         id_q       <= 8'h00;
         val_q      <= 16'h0000;
         csum_q     <= 8'h00;
         rr_q       <= 2'd0;
         drop_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         id_q       <= id_d;
         val_q      <= val_d;
         csum_q     <= csum_d;
         rr_q       <= rr_d;
         drop_q     <= drop_d;
      end
   end

   assign o_tx_valid = tx_valid_q;
   assign o_tx_data  = tx_data_q;
   assign o_drop_cnt = drop_q;
   assign o_busy     = (state_q != ST_IDLE) | (|pend);

endmodule

// File: doc/eval_report_tx.md
Name: eval_report_tx

Overview:
- Transmit side of the performance-evaluation path: samples the windowed branch-accuracy, IPC and memory-penalty results each time the evaluation block publishes a new value.
- Packs each result into a 5-byte frame and streams it over a byte-wide valid/ready interface to the debug UART TX.
- Sits between the evaluation counters and the UART, so results can be read off-chip without a CSR bus.

Parameters:
- BR_W, 10, width of branch-correct result (must be 1..16)
- IPC_W, 10, width of IPC result (must be 1..16)
- MEM_W, 7, width of memory-penalty result (must be 1..16)
- HDR_BYTE, 8'hA5, frame start marker

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_br_eval  in  BR_W  branch-correct result
- i_br_upd  in  1  one-cycle pulse: i_br_eval holds a new value this cycle
- i_ipc_eval  in  IPC_W  IPC result
- i_ipc_upd  in  1  one-cycle pulse: i_ipc_eval new
- i_mem_eval  in  MEM_W  memory-penalty result
- i_mem_upd  in  1  one-cycle pulse: i_mem_eval new
- o_tx_valid  out  1  byte available
- o_tx_data  out  8  byte payload
- i_tx_ready  in  1  downstream accepts byte when valid&ready at posedge
- o_drop_cnt  out  8  saturating count of overwritten (lost) results
- o_busy  out  1  frame in flight or any slot pending

Behaviour:
- Reset: async assert clears all state immediately. o_tx_valid=0, o_tx_data=0, o_drop_cnt=0, o_busy=0, all pending=0, round-robin pointer points at BR. Reset mid-frame abandons the frame; no resume.
- Slots: one per source (ID BR=8'h01, IPC=8'h02, MEM=8'h03). Each holds a 16-bit zero-extended value plus a pending flag.
  - upd pulse at posedge: value<=input, pending<=1.
  - If pending was already 1 and the FSM is not capturing that slot this cycle: value overwritten, o_drop_cnt+1, saturating at 255.
  - Capture and upd on the same slot in the same cycle: capture takes the old value, pending stays 1 with the new value, no drop.
- Arbitration: round-robin among pending slots, starting from the slot after the last one served; after reset order is BR, IPC, MEM.
- FSM states: IDLE, HDR, ID, VHI, VLO, CSUM.
  - IDLE: if any pending, capture the chosen slot (id, value, csum = id ^ val[15:8] ^ val[7:0]), clear its pending, go to HDR.
  - HDR..CSUM: drive o_tx_valid=1 with HDR_BYTE, id, val[15:8], val[7:0], csum respectively. Advance only on valid&ready.
  - CSUM accept -> IDLE. No back-to-back bypass: one IDLE cycle between frames.
- Handshake: while o_tx_valid=1 and i_tx_ready=0, o_tx_data stable. o_tx_valid never drops before acceptance. o_tx_data=0 in IDLE.
- Latency: upd pulse sampled at edge N -> pending visible after N -> FSM captures at edge N+1 -> o_tx_valid=1 with HDR_BYTE after edge N+1. Minimum frame = 5 accepted cycles + 1 IDLE.
- o_busy = (state!=IDLE) | any pending.

Decomposition:
- Package eval_report_pkg holds:
  - HDR default
  - ID constants (ID_BR, ID_IPC, ID_MEM)
  - state enum
  - FRAME_LEN=5
  - helper function for the XOR checksum
- One sub-module, eval_report_slot: holding register, pending flag, overwrite-detect output. Instantiated three times with a width parameter.

Test Plan:
- Single BR update, i_br_eval=10'd999, ready=1 -> bytes A5 01 03 E7 E5 on consecutive cycles, valid first high 2 cycles after pulse edge.
- Simultaneous pulses, br=999, ipc=500, mem=100 -> frames in order A5 01 03 E7 E5, A5 02 01 F4 F7, A5 03 00 64 67; o_drop_cnt=0.
- ready=0, br pulses 5, then 6, then 7 -> first frame carries 5; frame 6 is lost; o_drop_cnt=1; after ready=1, frames with val 0x0005 then 0x0007; o_busy=0 afterwards.
- Backpressure: ready low for 10 cycles during the VHI byte of ipc=500 -> o_tx_valid=1 and o_tx_data=8'h01 held all 10 cycles; stream resumes F4 F7.
- 300 overwrites with ready=0 -> o_drop_cnt saturates at 255; no wrap.
- Assert i_rst_n=0 mid-frame (after ID byte) -> o_tx_valid=0 the same cycle; after release, no bytes sent until a new upd pulse.
